// File: rtl/ring_seq_pkg.sv
// Shared types, default sizes and bit helpers for the ring step sequencer.
// Helpers work on a wide vector so they serve any ring width up to MAX_W.
package ring_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_DIV_W = 8;
   localparam int MAX_W     = 64;

   // Nonzero and clearing the lowest set bit leaves nothing behind.
   function automatic logic is_onehot(input logic [MAX_W-1:0] value);
      return (value != '0) && ((value & (value - MAX_W'(1))) == '0);
   endfunction

   // Rotate the low `width` bits by one place.
   // dir 0 moves toward the MSB and dir 1 moves toward the LSB.
   function automatic logic [MAX_W-1:0] rotate(input logic [MAX_W-1:0] value,
                                                input int width,
                                                input logic dir);
      logic [MAX_W-1:0] result;
      result = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < width) begin
            result[i] = dir ? value[(i + 1) % width] : value[(i + width - 1) % width];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/ring_seq_prescaler.sv
// Rate divider: emits one strobe every reload+1 cycles while not held.
// The divider value is captured at load and reused for every later period.
module ring_seq_prescaler
   import ring_seq_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic             hold,
   input  logic [DIV_W-1:0] load_val,
   output logic             strobe
);

   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] reload;

   always_ff @(posedge clk) begin
      if (clear) begin
         count  <= '0;
         reload <= '0;
      end else if (load) begin
         count  <= load_val;
         reload <= load_val;
      end else if (!hold) begin
         count <= (count == '0) ? reload : count - DIV_W'(1);
      end
   end

   assign strobe = !hold && (count == '0);

endmodule

// File: rtl/ring_step_sequencer.sv
// Command-driven sequencer for a one-hot ring.
// It accepts seed, steps, rate and direction, rotates at the programmed rate and pulses done at the end.
module ring_step_sequencer
   import ring_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W,
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_seed,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0] cmd_div,
   input  logic             cmd_dir,
   input  logic             halt,
   input  logic             abort,
   output logic [WIDTH-1:0] ring,
   output logic             step,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] ring_q;
   logic [CNT_W-1:0] remaining;
   logic             dir_q;
   logic             step_q;
   logic             err_q;

   logic accept;
   logic seed_ok;
   logic advance;
   logic tick;
   logic start_run;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign ring      = ring_q;
   assign step      = step_q;
   assign err       = err_q;

   assign accept    = cmd_valid && cmd_ready;
   assign seed_ok   = is_onehot(MAX_W'(cmd_seed));
   assign start_run = accept && seed_ok && (cmd_steps != '0);
   // Abort outranks halt, and both freeze the prescaler so no rotation can slip through.
   assign advance   = (state == RUN) && !halt && !abort;

   ring_seq_prescaler #(
      .DIV_W(DIV_W)
   ) u_prescaler (
      .clk     (clk),
      .clear   (rst),
      .load    (start_run),
      .hold    (!advance),
      .load_val(cmd_div),
      .strobe  (tick)
   );

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept && seed_ok) begin
               state_next = (cmd_steps == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
            end else if (tick && (remaining == CNT_W'(1))) begin
               state_next = DONE;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ring_q    <= WIDTH'(1);
         remaining <= '0;
         dir_q     <= 1'b0;
         step_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state  <= state_next;
         step_q <= tick;
         if (accept) begin
            if (!seed_ok) begin
               err_q <= 1'b1;
            end else begin
               err_q     <= 1'b0;
               ring_q    <= cmd_seed;
               remaining <= cmd_steps;
               dir_q     <= cmd_dir;
            end
         end
         if (tick) begin
            ring_q    <= WIDTH'(rotate(MAX_W'(ring_q), WIDTH, dir_q));
            remaining <= remaining - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ring_step_sequencer.sv
// Self-checking bench for ring_step_sequencer.
// A behavioural model counts unhalted run cycles and rotates on every (D+1)th one.
module tb_ring_step_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_seed = 8'h00;
   logic [7:0] cmd_steps = 8'h00;
   logic [7:0] cmd_div = 8'h00;
   logic       cmd_dir = 1'b0;
   logic       halt = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] ring;
   logic       step;
   logic       busy;
   logic       done;
   logic       err;

   int compared = 0;
   int mismatched = 0;

   // Behavioural model: phase 0 idle, 1 running, 2 finishing
   int         m_phase = 0;
   logic [7:0] m_ring = 8'h01;
   int         m_left = 0;
   int         m_elapsed = 0;
   int         m_div = 0;
   logic       m_dir = 1'b0;
   logic       m_err = 1'b0;
   logic       m_step = 1'b0;

   ring_step_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_seed (cmd_seed),
      .cmd_steps(cmd_steps),
      .cmd_div  (cmd_div),
      .cmd_dir  (cmd_dir),
      .halt     (halt),
      .abort    (abort),
      .ring     (ring),
      .step     (step),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance the model by one clock edge using the inputs the DUT sees at that edge.
   task automatic model_edge();
      if (rst) begin
         m_phase = 0; m_ring = 8'h01; m_left = 0; m_elapsed = 0;
         m_err = 1'b0; m_step = 1'b0;
      end else begin
         m_step = 1'b0;
         case (m_phase)
            0: begin
               if (cmd_valid) begin
                  if ($countones(cmd_seed) != 1) begin
                     m_err = 1'b1;
                  end else begin
                     m_err = 1'b0;
                     m_ring = cmd_seed;
                     m_left = int'(cmd_steps);
                     m_div = int'(cmd_div);
                     m_dir = cmd_dir;
                     m_elapsed = 0;
                     m_phase = (cmd_steps == 8'd0) ? 2 : 1;
                  end
               end
            end
            1: begin
               if (abort) begin
                  m_phase = 0;
               end else if (!halt) begin
                  m_elapsed++;
                  if (m_elapsed % (m_div + 1) == 0) begin
                     m_ring = m_dir ? {m_ring[0], m_ring[7:1]} : {m_ring[6:0], m_ring[7]};
                     m_step = 1'b1;
                     m_left--;
                     if (m_left == 0) m_phase = 2;
                  end
               end
            end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic check_outputs();
      check("ring", ring, m_ring);
      check("step", step, m_step);
      check("busy", busy, m_phase == 1);
      check("done", done, m_phase == 2);
      check("cmd_ready", cmd_ready, m_phase == 0);
      check("err", err, m_err);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Present a command for one edge, then scramble the fields to show they are not re-sampled.
   task automatic apply_command(input logic [7:0] seed, input logic [7:0] steps,
                                input logic [7:0] div, input logic dir);
      cmd_valid = 1'b1; cmd_seed = seed; cmd_steps = steps; cmd_div = div; cmd_dir = dir;
      tick();
      cmd_valid = 1'b0;
      cmd_seed = 8'($urandom); cmd_steps = 8'($urandom);
      cmd_div = 8'($urandom); cmd_dir = 1'($urandom);
   endtask

   initial begin
      ticks(2);
      check("reset_ring", ring, 8'h01);
      check("reset_ready", cmd_ready, 1'b1);
      rst = 1'b0;
      tick();

      apply_command(8'h01, 8'd3, 8'd0, 1'b0);
      ticks(5);
      apply_command(8'h01, 8'd2, 8'd2, 1'b1);
      ticks(3);
      check("wrap_first", ring, 8'h80);
      ticks(5);

      apply_command(8'h03, 8'd2, 8'd0, 1'b0);
      check("bad_seed_err", err, 1'b1);
      ticks(2);
      apply_command(8'h04, 8'd1, 8'd0, 1'b0);
      check("err_cleared", err, 1'b0);
      ticks(3);

      apply_command(8'h01, 8'd4, 8'd0, 1'b0);
      tick();
      halt = 1'b1;
      ticks(3);
      halt = 1'b0;
      ticks(6);

      apply_command(8'h01, 8'd4, 8'd0, 1'b0);
      ticks(2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_ring", ring, 8'h04);
      check("abort_ready", cmd_ready, 1'b1);
      ticks(2);

      apply_command(8'h10, 8'd0, 8'd3, 1'b0);
      check("zero_steps_done", done, 1'b1);
      ticks(2);
      apply_command(8'h01, 8'd5, 8'd1, 1'b0);
      ticks(3);
      rst = 1'b1;
      tick();
      check("mid_run_reset_ring", ring, 8'h01);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 600; i++) begin
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_seed  = ($urandom_range(0, 3) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
         cmd_steps = 8'($urandom_range(0, 5));
         cmd_div   = 8'($urandom_range(0, 3));
         cmd_dir   = 1'($urandom);
         halt      = ($urandom_range(0, 5) == 0);
         abort     = ($urandom_range(0, 19) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ring_step_sequencer.md
# ring_step_sequencer

Controller that sequences a one-hot ring counter for the TinyTapeout ring-counter design. It accepts a command (seed pattern, step count, rate divider, direction) over a valid/ready handshake, steps the ring at the programmed rate, and reports completion. It sits between the `ui_in`/`uio_in` decode logic and the ring register that drives `uo_out`.

## Interface
Parameters:
- `WIDTH`, 8: ring positions; ring is `WIDTH` bits, one-hot.
- `CNT_W`, 8: width of the step count.
- `DIV_W`, 8: width of the rate divider.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a clock edge.
- `cmd_seed`  in  WIDTH  initial ring pattern; must be one-hot.
- `cmd_steps`  in  CNT_W  number of rotations to perform.
- `cmd_div`  in  DIV_W  divider D; one step every D+1 cycles.
- `cmd_dir`  in  1  0 = rotate toward MSB (bit W-1 wraps to bit 0); 1 = rotate toward LSB.
- `halt`  in  1  pause while high.
- `abort`  in  1  terminate the run.
- `ring`  out  WIDTH  current ring value.
- `step`  out  1  one-cycle pulse, high in the cycle where the rotated value is first visible.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky error: last command's seed was not one-hot.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset values: state IDLE, `ring` = 1 (bit 0), `step` = 0, `busy` = 0, `done` = 0, `err` = 0, internal counters 0.
- `cmd_ready` = 1 only in IDLE. `busy` = 1 only in RUN. `done` = 1 only in DONE.
- **IDLE, command accepted:**
  - Seed not one-hot (zero, or more than one bit set): `err` <= 1, `ring` is unchanged, stay in IDLE.
  - Otherwise: `err` <= 0 and `ring` <= `cmd_seed`.
    - `cmd_steps` == 0: go to DONE.
    - Otherwise: remaining <= `cmd_steps`, prescale <= `cmd_div`, direction is latched, go to RUN.
- **RUN:** each cycle with `halt` = 0 and `abort` = 0:
  - prescale != 0: decrement prescale.
  - prescale == 0: rotate `ring` one position, assert `step`, reload prescale from the latched D, decrement remaining.
    - If remaining reaches 0, go to DONE.
- `halt` = 1 freezes prescale, remaining and `ring`.
- `abort` = 1 in RUN: go to IDLE next edge. `ring` holds its current value, no rotation that cycle, no `done`.
- **DONE:** one cycle with `done` = 1, then go to IDLE.
- Command fields are sampled only at acceptance; changes during RUN are ignored.
- Counter arithmetic is unsigned. Remaining never underflows, because the 0 case is caught at acceptance.

## Timing
- Acceptance at edge t:
  - `ring` = seed from cycle t+1.
  - First rotation at edge t+D+1.
  - Subsequent rotations every D+1 unhalted cycles.
- The last rotation edge moves the FSM to DONE: `done` is high in the same cycle as the final `step`. Next command accepted one cycle later.
- steps = 0: `done` is high in cycle t+1.
- Each cycle of `halt` delays every later step by exactly one cycle.
- Priority, highest first: `rst` > `abort` > `halt` > normal stepping.
  - `abort` coinciding with a due rotation: no rotation.
  - `abort` in IDLE or DONE is ignored.
- `rst` mid-run: all outputs return to reset values at the next edge, including `ring` = 1.
- `cmd_valid` while not in IDLE: no effect, command is held off by `cmd_ready` = 0.

## Structure
- Package `ring_seq_pkg`:
  - state enum (IDLE, RUN, DONE);
  - default `WIDTH`/`CNT_W`/`DIV_W` constants;
  - `is_onehot` function;
  - `rotate` function (value, dir).
- One sub-module: `ring_seq_prescaler`, the D+1 cycle strobe generator with load/hold/clear inputs.
- FSM, step counter and ring register live in the top-level module.

## Test plan
- Reset: `rst` high for 2 edges -> `ring` = 8'h01, `cmd_ready` = 1, all other outputs 0.
- Seed 8'h01, steps 3, div 0, dir 0 -> `ring` 01, 02, 04, 08 on consecutive cycles; `step` high 3 cycles; `done` with the 08 cycle.
- Seed 8'h01, steps 2, div 2, dir 1 -> `ring` 80 at t+3, 40 at t+6 (wrap-around); `busy` high t+1..t+6.
- Seed 8'h03 -> `err` = 1, `ring` unchanged, FSM stays IDLE. Next valid command -> `err` = 0.
- Run with steps 4, div 0: `halt` for 3 cycles after the first step -> remaining steps are shifted by exactly 3 cycles. `abort` after the second step -> `ring` holds 04, no `done`, `cmd_ready` = 1 next cycle.
- steps 0 with seed 8'h10 -> `ring` = 10, `done` pulse at t+1, no `step`. `rst` asserted mid-run -> `ring` = 01 next cycle.
